// File: rtl/nonce_uart_tx.sv
// Icarus result transmitter: queues golden nonces and sends each one as four
// 8N1 bytes, most significant byte first, on the TxD line.
module nonce_uart_tx #(
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] golden_nonce,
  input  logic        golden_nonce_match,
  output logic        TxD,
  output logic        busy,
  output logic [4:0]  fifo_count,
  output logic        overflow
);
  localparam int unsigned BAUD_W = 16;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [31:0]       holder, holder_n;
  logic [BAUD_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [1:0]        byte_idx, byte_idx_n;
  logic [4:0]        count_n;
  logic [7:0]        cur_byte;
  logic              txd_n, pop, push, wrap;

  // Next-state, line value and FIFO bookkeeping.
  always_comb begin
    state_n    = state;
    txd_n      = TxD;
    holder_n   = holder;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    pop        = 1'b0;
    cur_byte   = holder[31:24];
    wrap       = (baud_cnt == BAUD_LAST);

    if (state inside {START, DATA, STOP})
      baud_cnt_n = wrap ? '0 : baud_cnt + BAUD_W'(1);

    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (fifo_count != '0) begin
          pop      = 1'b1;
          holder_n = mem[rd_ptr];
          state_n  = LOAD;
        end
      end
      LOAD: begin
        byte_idx_n = '0;
        bit_idx_n  = '0;
        baud_cnt_n = '0;
        txd_n      = 1'b0;
        state_n    = START;
      end
      START: begin
        if (wrap) begin
          bit_idx_n = '0;
          txd_n     = cur_byte[0];
          state_n   = DATA;
        end
      end
      DATA: begin
        if (wrap) begin
          if (bit_idx == 3'd7) begin
            txd_n   = 1'b1;
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            txd_n     = cur_byte[bit_idx + 3'd1];
          end
        end
      end
      STOP: begin
        if (wrap) begin
          if (byte_idx != 2'd3) begin
            byte_idx_n = byte_idx + 2'd1;
            holder_n   = {holder[23:0], 8'h00};
            txd_n      = 1'b0;
            state_n    = START;
          end else begin
            txd_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A pop frees a slot on the same edge, so a full FIFO still accepts then.
    push    = golden_nonce_match && ((fifo_count < DEPTH_CNT) || pop);
    count_n = fifo_count + 5'(push) - 5'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      TxD        <= 1'b1;
      busy       <= 1'b0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      holder     <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
    end else begin
      TxD        <= txd_n;
      busy       <= (state_n != IDLE) || (count_n != '0);
      fifo_count <= count_n;
      overflow   <= golden_nonce_match && !push;
      holder     <= holder_n;
      baud_cnt   <= baud_cnt_n;
      bit_idx    <= bit_idx_n;
      byte_idx   <= byte_idx_n;
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
    end
  end

  // Storage array carries no reset; validity is tracked by fifo_count.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= golden_nonce;
  end
endmodule

// File: doc/nonce_uart_tx.md
Name: nonce_uart_tx

Overview:
Downstream stage of the ltcminer_icarus core. It captures each golden nonce the hasher reports and serialises it to the host over the TxD UART line using the Icarus result protocol: 4 bytes per nonce, 8N1. A small FIFO absorbs back-to-back shares found while a previous nonce is still being transmitted.

Parameters:
BAUD_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
FIFO_DEPTH, 4, number of pending nonces held; power of two, 2..16.

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high; clears FIFO and FSM
golden_nonce  input  32  nonce value, valid when golden_nonce_match=1
golden_nonce_match  input  1  one-cycle push strobe; each high cycle is one nonce
TxD  output  1  UART serial out, idle high
busy  output  1  high while a frame is being shifted or the FIFO is non-empty
fifo_count  output  5  number of nonces queued, not counting the one in flight
overflow  output  1  one-cycle pulse when a push is dropped because the FIFO is full

Behaviour:
- Reset values: TxD=1, busy=0, fifo_count=0, overflow=0. FSM=IDLE. Bit and baud counters=0.
- Reset has priority over every other event. If reset is asserted mid-frame, TxD is 1 on the next edge and the partial byte is abandoned. Queued nonces are discarded.
- FIFO push: on an edge with golden_nonce_match=1, golden_nonce is written if fifo_count<FIFO_DEPTH. If the FIFO is full, the nonce is dropped and overflow=1 for exactly that next cycle. Contents are unchanged.
- FIFO pop: happens when the FSM leaves IDLE (LOAD). A push and a pop on the same edge are both honoured, including when the FIFO is full; fifo_count is then unchanged.
- FSM states:
  - IDLE: TxD=1. If fifo_count>0, go to LOAD.
  - LOAD: pop the head nonce into a 32-bit shift holder and set byte_idx=0. Go to START.
  - START: TxD=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: shift out 8 bits, LSB first, each for BAUD_DIV cycles, then go to STOP.
  - STOP: TxD=1 for BAUD_DIV cycles. If byte_idx<3, increment byte_idx and go to START. Otherwise return to IDLE.
- Byte order: most significant byte first. byte0=nonce[31:24], byte3=nonce[7:0].
- There is no inter-byte gap. There is no gap between nonces either: from STOP, IDLE sees a non-empty FIFO and LOAD follows, giving a fixed 2 cycles of idle-high.
- Latency: for a match sampled at edge E with the FSM in IDLE and the FIFO empty:
  - fifo_count=1 after E.
  - LOAD runs at E+1.
  - TxD=0 after edge E+2.
- Frame length: 40*BAUD_DIV cycles per nonce, plus the 2 IDLE/LOAD cycles.
- The baud counter counts 0..BAUD_DIV-1 and wraps. Bit transitions occur only on a wrap.
- busy = (FSM != IDLE) || (fifo_count != 0).
- TxD is driven from a register so that it is glitch-free.
- fifo_count width is 5 bits for any legal FIFO_DEPTH. The FIFO read and write pointers wrap modulo FIFO_DEPTH.

Test Plan:
1. BAUD_DIV=4, single push of 0x12345678 -> TxD falls 2 cycles after the push. The decoded bytes are 0x12, 0x34, 0x56, 0x78. Each bit lasts 4 cycles. busy falls 160+2 cycles after the push. overflow never pulses.
2. Push 0xDEADBEEF, then 0x00000001 one cycle later -> fifo_count peaks at 1. The line carries DE AD BE EF 00 00 00 01, with exactly 2 idle-high cycles between the two frames.
3. FIFO_DEPTH=4, push 6 nonces on consecutive cycles while the first is in flight -> the 2nd..5th are queued (fifo_count=4) and the 6th is dropped with a 1-cycle overflow pulse. The serial output is nonces 1..5 in order.
4. FIFO full with FSM in STOP of the last byte, and a push on the same edge as LOAD -> the push is accepted, fifo_count stays 4, and overflow stays 0.
5. Assert reset for 1 cycle during the DATA bit 3 of byte1 with 2 nonces queued -> next cycle TxD=1, fifo_count=0, busy=0. There is no further line activity, and a new push transmits normally.
6. Default BAUD_DIV=868, push 0xA5A5A5A5 -> each bit lasts 868 cycles and the start bit is detected by a reference UART receiver model. The decoded result is four bytes of 0xA5.
